// File: rtl/ssdisp_pkg.sv
// Shared constants for the 4-digit display controller: register map, modes,
// digit byte layout and scroll position limit.
package ssdisp_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RAW    = 2'd1;
    localparam logic [1:0] ADDR_VALUE  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] MODE_DIRECT     = 2'd0;
    localparam logic [1:0] MODE_SCROLL     = 2'd1;
    localparam logic [1:0] MODE_FREEZE     = 2'd2;
    localparam logic [1:0] MODE_DIRECT_ALT = 2'd3;

    localparam int NUM_LSB = 0;
    localparam int PT_BIT  = 4;
    localparam int EN_BIT  = 7;

    localparam logic [2:0]  POS_MAX = 3'd4;
    localparam logic [31:0] EN_MASK = {4{8'(1 << EN_BIT)}};

    typedef struct packed {
        logic       en;
        logic [1:0] rsvd;
        logic       pt;
        logic [3:0] num;
    } digit_t;

    function automatic digit_t make_digit(input logic [3:0] num, input logic pt, input logic en);
        digit_t d;
        d.en   = en;
        d.rsvd = 2'b00;
        d.pt   = pt;
        d.num  = num;
        return d;
    endfunction

endpackage

// File: rtl/ssdisp_tick.sv
// Display tick prescaler: counts 0..TICK_DIV-1 and pulses TICK on the wrap cycle.
module ssdisp_tick #(
    parameter int TICK_DIV = 100000
) (
    input  logic CLK,
    input  logic RES,
    output logic TICK
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RES) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/ssdisp_ctrl.sv
// 4-digit seven-segment display controller with bus registers, direct/scroll/freeze
// modes and optional blinking (enabled by defining SSDISP_BLINK_EN).
module ssdisp_ctrl
    import ssdisp_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        XRD,
    input  logic        XWR,
    input  logic [1:0]  XADDR,
    input  logic [31:0] XDATA_IN,
    output logic [31:0] XDATA_OUT,
    output logic        XACK,
    output logic [31:0] SSDISP_REG_FF
);

    logic        tick;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  mode_q;
    logic [7:0]  period_q;
    logic [31:0] raw_q, value_q;
    logic [2:0]  pos_q, pos_d;
    logic [7:0]  step_q, step_d;
    logic [31:0] disp_q, disp_d;
    logic [31:0] window, blink_mask;
    logic        blink_rd;

    ssdisp_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK  (CLK),
        .RES  (RES),
        .TICK (tick)
    );

    logic accept, wr, rd, wr_ctrl, wr_raw, wr_value, clear_pos, step_en, step_done, scrolling;

    assign accept   = ~ack_q & (XRD | XWR);
    assign wr       = accept & XWR;
    assign rd       = accept & ~XWR;
    assign wr_ctrl  = wr && (XADDR == ADDR_CTRL);
    assign wr_raw   = wr && (XADDR == ADDR_RAW);
    assign wr_value = wr && (XADDR == ADDR_VALUE);

    // Entering FREEZE keeps pos so the last scroll window stays on screen.
    assign clear_pos = wr_value ||
                       (wr_ctrl && (XDATA_IN[1:0] != mode_q) && (XDATA_IN[1:0] != MODE_FREEZE));

    assign scrolling = (mode_q == MODE_SCROLL) && (period_q != 8'd0);
    assign step_en   = scrolling && tick;
    assign step_done = step_en && (step_q >= period_q - 8'd1);

    always_comb begin
        pos_d  = pos_q;
        step_d = step_q;
        if (clear_pos) begin
            pos_d  = '0;
            step_d = '0;
        end else if (step_done) begin
            step_d = '0;
            pos_d  = (pos_q == POS_MAX) ? 3'd0 : pos_q + 3'd1;
        end else if (step_en) begin
            step_d = step_q + 8'd1;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            unique case (XADDR)
                ADDR_CTRL:   rdata_d = {16'h0, period_q, 5'h0, blink_rd, mode_q};
                ADDR_RAW:    rdata_d = raw_q;
                ADDR_VALUE:  rdata_d = value_q;
                ADDR_STATUS: rdata_d = {28'h0, scrolling, pos_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            logic [3:0] nib_idx;
            assign nib_idx = {1'b0, pos_q} + 4'(gi);
            assign window[8*gi +: 8] = make_digit(4'(value_q >> {nib_idx, 2'b00}), 1'b0, 1'b1);
        end
    endgenerate

`ifdef SSDISP_BLINK_EN
    logic       blink_q, phase_q;
    logic [7:0] blink_cnt_q;
    logic       unused_xdata;

    always_ff @(posedge CLK) begin
        if (RES) begin
            blink_q     <= 1'b0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            if (wr_ctrl) blink_q <= XDATA_IN[2];
            if (tick) begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
                if (blink_cnt_q == 8'hFF) phase_q <= ~phase_q;
            end
        end
    end

    assign blink_mask   = (blink_q && !phase_q) ? EN_MASK : '0;
    assign blink_rd     = blink_q;
    assign unused_xdata = ^{XDATA_IN[31:16], XDATA_IN[7:3]};
`else
    logic unused_xdata;
    assign blink_mask   = '0;
    assign blink_rd     = 1'b0;
    assign unused_xdata = ^{XDATA_IN[31:16], XDATA_IN[7:2]};
`endif

    always_comb begin
        disp_d = ((mode_q == MODE_SCROLL) || (mode_q == MODE_FREEZE)) ? window : raw_q;
        disp_d = disp_d & ~blink_mask;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            mode_q   <= MODE_DIRECT;
            period_q <= '0;
            raw_q    <= '0;
            value_q  <= '0;
            pos_q    <= '0;
            step_q   <= '0;
            disp_q   <= '0;
        end else begin
            ack_q   <= accept;
            rdata_q <= rdata_d;
            if (wr_ctrl) begin
                mode_q   <= XDATA_IN[1:0];
                period_q <= XDATA_IN[15:8];
            end
            if (wr_raw)   raw_q   <= XDATA_IN;
            if (wr_value) value_q <= XDATA_IN;
            pos_q  <= pos_d;
            step_q <= step_d;
            disp_q <= disp_d;
        end
    end

    assign XACK          = ack_q;
    assign XDATA_OUT     = rdata_q;
    assign SSDISP_REG_FF = disp_q;

endmodule

// File: tb/tb_ssdisp_ctrl.sv
// Bench for ssdisp_ctrl with TICK_DIV=4: register table, directed scroll/freeze/blink
// sequences and randomized bus traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_ssdisp_ctrl;

    localparam int TD = 4;
    localparam logic [1:0] A_CTRL = 2'd0, A_RAW = 2'd1, A_VALUE = 2'd2, A_STATUS = 2'd3;
`ifdef SSDISP_BLINK_EN
    localparam bit HAS_BLINK = 1'b1;
`else
    localparam bit HAS_BLINK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        XRD = 1'b0;
    logic        XWR = 1'b0;
    logic [1:0]  XADDR = 2'd0;
    logic [31:0] XDATA_IN = 32'h0;
    logic [31:0] XDATA_OUT, SSDISP_REG_FF;
    logic        XACK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    ssdisp_ctrl #(.TICK_DIV(TD)) dut (
        .CLK           (CLK),
        .RES           (RES),
        .XRD           (XRD),
        .XWR           (XWR),
        .XADDR         (XADDR),
        .XDATA_IN      (XDATA_IN),
        .XDATA_OUT     (XDATA_OUT),
        .XACK          (XACK),
        .SSDISP_REG_FF (SSDISP_REG_FF)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_raw, m_value, m_rdata, m_disp;
    logic [1:0]  m_mode;
    logic [7:0]  m_period;
    logic        m_blink, m_ack;
    int          m_pos, m_steps, m_edge, m_ticks;
    logic        m_acc, m_wr, m_rd, m_clr, m_tick, m_step;

    function automatic logic [31:0] m_window(input logic [31:0] v, input int p);
        logic [31:0] w;
        w = '0;
        for (int n = 0; n < 4; n++) w[8*n +: 8] = 8'h80 | 8'((v >> (4 * (p + n))) & 32'hF);
        return w;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic scr;
        scr = (m_mode == 2'd1) && (m_period != 8'd0);
        case (a)
            A_CTRL:  return {16'h0, m_period, 5'h0, m_blink, m_mode};
            A_RAW:   return m_raw;
            A_VALUE: return m_value;
            default: return {28'h0, scr, 3'(m_pos)};
        endcase
    endfunction

    function automatic logic [31:0] m_source();
        logic [31:0] s;
        s = (m_mode == 2'd1 || m_mode == 2'd2) ? m_window(m_value, m_pos) : m_raw;
        if (m_blink && ((m_ticks / 256) % 2 == 0)) s = s & ~32'h8080_8080;
        return s;
    endfunction

    always_comb begin
        m_acc  = !m_ack && (XRD || XWR);
        m_wr   = m_acc && XWR;
        m_rd   = m_acc && !XWR;
        m_clr  = m_wr && (XADDR == A_VALUE ||
                 (XADDR == A_CTRL && XDATA_IN[1:0] != m_mode && XDATA_IN[1:0] != 2'd2));
        m_tick = (m_edge % TD) == TD - 1;
        m_step = (m_mode == 2'd1) && (m_period != 8'd0) && m_tick && (m_steps + 1 >= int'(m_period));
    end

    always @(posedge CLK) begin
        if (RES) begin
            m_raw <= '0; m_value <= '0; m_rdata <= '0; m_disp <= '0;
            m_mode <= '0; m_period <= '0; m_blink <= 1'b0; m_ack <= 1'b0;
            m_pos <= 0; m_steps <= 0; m_edge <= 0; m_ticks <= 0;
        end else begin
            m_edge  <= m_edge + 1;
            m_ticks <= m_ticks + (m_tick ? 1 : 0);
            m_ack   <= m_acc;
            m_rdata <= m_rd ? m_read(XADDR) : 32'h0;
            m_disp  <= m_source();
            if (m_wr && XADDR == A_CTRL) begin
                m_mode   <= XDATA_IN[1:0];
                m_period <= XDATA_IN[15:8];
                m_blink  <= HAS_BLINK && XDATA_IN[2];
            end
            if (m_wr && XADDR == A_RAW)   m_raw   <= XDATA_IN;
            if (m_wr && XADDR == A_VALUE) m_value <= XDATA_IN;
            if (m_clr) begin
                m_pos <= 0; m_steps <= 0;
            end else if (m_step) begin
                m_steps <= 0; m_pos <= (m_pos + 1) % 5;
            end else if (m_mode == 2'd1 && m_period != 8'd0 && m_tick) begin
                m_steps <= m_steps + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        if (chk_en) begin
            check("model_ack", 32'(XACK), 32'(m_ack));
            check("model_rdata", XDATA_OUT, m_rdata);
            check("model_disp", SSDISP_REG_FF, m_disp);
        end
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] q);
        XRD = rd; XWR = wr; XADDR = a; XDATA_IN = d;
        cyc();
        check("bus_ack", 32'(XACK), 32'd1);
        q = XDATA_OUT;
        XRD = 1'b0; XWR = 1'b0;
        cyc();
        $display("bus rd=%0d wr=%0d addr=%0d data=%h -> %h", rd, wr, a, d, q);
    endtask

    task automatic wait_change(input logic [31:0] old, output int n);
        n = 0;
        while (SSDISP_REG_FF === old && n < 40) begin
            cyc();
            n++;
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] q, prev;
        logic [31:0] seq [5];
        int n, k, bad, ntr, last;

        tbl[0]  = '{1'b0, 1'b1, A_CTRL,   32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, A_CTRL,   32'h0, {16'h0, 8'hFF, 5'h0, HAS_BLINK, 2'b11}};
        tbl[2]  = '{1'b0, 1'b1, A_RAW,    32'h1234_5678, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, A_RAW,    32'h0, 32'h1234_5678};
        tbl[4]  = '{1'b0, 1'b1, A_VALUE,  32'hCAFE_BABE, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, A_VALUE,  32'h0, 32'hCAFE_BABE};
        tbl[6]  = '{1'b0, 1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, A_STATUS, 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, A_RAW,    32'hA5A5_A5A5, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, A_RAW,    32'h0, 32'hA5A5_A5A5};
        tbl[10] = '{1'b0, 1'b1, A_CTRL,   32'h0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, A_CTRL,   32'h0, 32'h0};

        // reset and idle
        RES = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_disp", SSDISP_REG_FF, 32'h0);
        check("reset_ack", 32'(XACK), 32'h0);
        check("reset_rdata", XDATA_OUT, 32'h0);
        RES = 1'b0;
        chk_en = 1'b1;
        repeat (3) cyc();
        check("idle_disp", SSDISP_REG_FF, 32'h0);

        foreach (tbl[i]) begin
            bus(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, q);
            check($sformatf("tbl%0d_data", i), q, tbl[i].exp);
        end

        // RAW write latency in DIRECT mode
        XWR = 1'b1; XADDR = A_RAW; XDATA_IN = 32'h8F9A_8B81;
        cyc();
        check("raw_ack_+1", 32'(XACK), 32'd1);
        check("raw_disp_+1", SSDISP_REG_FF, 32'hA5A5_A5A5);
        XWR = 1'b0;
        cyc();
        check("raw_ack_+2", 32'(XACK), 32'd0);
        check("raw_disp_+2", SSDISP_REG_FF, 32'h8F9A_8B81);
        bus(1'b1, 1'b0, A_RAW, 32'h0, q);
        check("raw_read", q, 32'h8F9A_8B81);

        // scrolling with period 2
        bus(1'b0, 1'b1, A_VALUE, 32'h8765_4321, q);
        bus(1'b0, 1'b1, A_CTRL, 32'h0000_0201, q);
        check("scroll_start", SSDISP_REG_FF, 32'h8483_8281);
        seq[0] = 32'h8584_8382; seq[1] = 32'h8685_8483; seq[2] = 32'h8786_8584;
        seq[3] = 32'h8887_8685; seq[4] = 32'h8483_8281;
        prev = SSDISP_REG_FF;
        for (int i = 0; i < 5; i++) begin
            wait_change(prev, n);
            check($sformatf("scroll_step%0d", i), SSDISP_REG_FF, seq[i]);
            if (i > 0) check($sformatf("scroll_gap%0d", i), 32'(n), 32'd8);
            prev = SSDISP_REG_FF;
        end

        // VALUE write colliding with a step
        k = 0;
        while (!(m_step && m_pos != 4) && k < 40) begin
            cyc();
            k++;
        end
        check("collide_found", 32'(k < 40), 32'd1);
        bus(1'b0, 1'b1, A_VALUE, 32'h0, q);
        check("collide_disp", SSDISP_REG_FF, 32'h8080_8080);
        bus(1'b1, 1'b0, A_STATUS, 32'h0, q);
        check("collide_status", q, 32'h0000_0008);

        // freeze at pos 3
        bus(1'b0, 1'b1, A_VALUE, 32'h8765_4321, q);
        k = 0;
        while (!(m_pos == 3 && !m_step) && k < 100) begin
            cyc();
            k++;
        end
        check("freeze_found", 32'(k < 100), 32'd1);
        bus(1'b0, 1'b1, A_CTRL, 32'h0000_0202, q);
        bus(1'b1, 1'b0, A_STATUS, 32'h0, q);
        check("freeze_status", q, 32'h0000_0003);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (SSDISP_REG_FF !== 32'h8786_8584) bad++;
        end
        check("freeze_hold", 32'(bad), 32'd0);
        bus(1'b1, 1'b0, A_STATUS, 32'h0, q);
        check("freeze_status_end", q, 32'h0000_0003);

        // blink
        bus(1'b0, 1'b1, A_RAW, 32'h8181_8181, q);
        bus(1'b0, 1'b1, A_CTRL, 32'h0000_0004, q);
`ifdef SSDISP_BLINK_EN
        prev = SSDISP_REG_FF; ntr = 0; last = 0;
        for (int i = 1; i <= 2600; i++) begin
            cyc();
            if (SSDISP_REG_FF !== prev) begin
                check("blink_val", SSDISP_REG_FF,
                      (prev == 32'h8181_8181) ? 32'h0101_0101 : 32'h8181_8181);
                if (ntr > 0) check("blink_gap", 32'(i - last), 32'd1024);
                ntr++; last = i; prev = SSDISP_REG_FF;
            end
        end
        check("blink_toggles", 32'(ntr >= 2), 32'd1);
`else
        bad = 0;
        for (int i = 0; i < 2600; i++) begin
            cyc();
            if (SSDISP_REG_FF !== 32'h8181_8181) bad++;
        end
        check("noblink_steady", 32'(bad), 32'd0);
`endif

        // randomized traffic including mid-operation resets
        for (int i = 0; i < 3000; i++) begin
            RES      = ($urandom_range(0, 199) == 0);
            XRD      = ($urandom_range(0, 3) == 0);
            XWR      = ($urandom_range(0, 3) == 0);
            XADDR    = 2'($urandom_range(0, 3));
            XDATA_IN = $urandom;
            if (XADDR == A_CTRL) XDATA_IN[15:8] = 8'($urandom_range(0, 3));
            cyc();
        end
        RES = 1'b0; XRD = 1'b0; XWR = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
